// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// edge_event_arbiter: per-channel rise/fall edge capture, round-robin
// serialised onto a single valid/ready event port.     Revision: 1.0
// ============================================================================
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    sig,
  input  logic [N-1:0]    cfg_rise,
  input  logic [N-1:0]    cfg_fall,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDXW-1:0] evt_ch,
  output logic            evt_fall,
  output logic [N-1:0]    overflow,
  input  logic            ovf_clr
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e          state_q;
  logic [N-1:0]    sig_q;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    ptype_q, ptype_d;
  logic [N-1:0]    ovf_q, ovf_d;
  logic [IDXW-1:0] rr_q;
  logic            evt_valid_q;
  logic [IDXW-1:0] evt_ch_q;
  logic            evt_fall_q;

  logic [N-1:0]    rise_w, fall_w, det_w, gnt_oh_w, load_w, ovf_new_w;
  logic [IDXW-1:0] hi_idx_w, lo_idx_w, gidx_w;
  logic            found_hi_w, found_lo_w, any_pend_w, do_grant_w, sel_fall_w;

  assign rise_w = sig & ~sig_q & cfg_rise;
  assign fall_w = ~sig & sig_q & cfg_fall;
  assign det_w  = rise_w | fall_w;

  // Round-robin: lowest pending index above rr_q wins, else wrap to the lowest overall.
  always_comb begin
    found_hi_w = 1'b0;
    found_lo_w = 1'b0;
    hi_idx_w   = '0;
    lo_idx_w   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        if (IDXW'(i) > rr_q) begin
          found_hi_w = 1'b1;
          hi_idx_w   = IDXW'(i);
        end else begin
          found_lo_w = 1'b1;
          lo_idx_w   = IDXW'(i);
        end
      end
    end
  end

  assign any_pend_w = found_hi_w | found_lo_w;
  assign gidx_w     = found_hi_w ? hi_idx_w : lo_idx_w;
  assign do_grant_w = any_pend_w & ((state_q == S_IDLE) | evt_ready);

  always_comb begin
    gnt_oh_w = '0;
    for (int i = 0; i < N; i++) begin
      gnt_oh_w[i] = do_grant_w & (gidx_w == IDXW'(i));
    end
  end

  assign sel_fall_w = |(ptype_q & gnt_oh_w);

  // A slot being granted this cycle is free to take a new edge without loss.
  assign load_w    = det_w & (~pend_q | gnt_oh_w);
  assign ovf_new_w = det_w & pend_q & ~gnt_oh_w;
  assign pend_d    = (pend_q & ~gnt_oh_w) | det_w;
  assign ptype_d   = (ptype_q & ~load_w) | (fall_w & load_w);
  assign ovf_d     = (ovf_clr ? '0 : ovf_q) | ovf_new_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sig_q       <= sig;
      pend_q      <= '0;
      ptype_q     <= '0;
      ovf_q       <= '0;
      rr_q        <= IDXW'(N - 1);
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_fall_q  <= 1'b0;
    end else begin
      sig_q   <= sig;
      pend_q  <= pend_d;
      ptype_q <= ptype_d;
      ovf_q   <= ovf_d;
      case (state_q)
        S_IDLE: begin
          if (do_grant_w) begin
            evt_valid_q <= 1'b1;
            evt_ch_q    <= gidx_w;
            evt_fall_q  <= sel_fall_w;
            rr_q        <= gidx_w;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (evt_ready) begin
            if (do_grant_w) begin
              evt_ch_q   <= gidx_w;
              evt_fall_q <= sel_fall_w;
              rr_q       <= gidx_w;
            end else begin
              evt_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_fall  = evt_fall_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// Bench for edge_event_arbiter: directed scenarios plus random traffic
// compared against a queue-free cycle model of the event rules.
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    sig, cfg_rise, cfg_fall, overflow;
  logic            evt_valid, evt_ready, evt_fall, ovf_clr;
  logic [IDXW-1:0] evt_ch;

  int checks = 0;
  int errors = 0;

  edge_event_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .sig(sig), .cfg_rise(cfg_rise), .cfg_fall(cfg_fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_fall(evt_fall), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: each cycle, hand the presented slot out first, then file new edges.
  bit          m_valid;
  int          m_ch;
  bit          m_fall;
  bit          m_pend [N];
  bit          m_ptype[N];
  bit          m_ovf  [N];
  bit          m_hist [N];
  int          m_rr;

  always @(posedge clk) begin : ref_model
    bit tp[N];
    bit tt[N];
    bit tov[N];
    bit er, ef, can;
    int win, trr, j;
    if (rst) begin
      m_valid <= 1'b0;
      m_ch    <= 0;
      m_fall  <= 1'b0;
      m_rr    <= N - 1;
      for (int i = 0; i < N; i++) begin
        m_pend[i]  <= 1'b0;
        m_ptype[i] <= 1'b0;
        m_ovf[i]   <= 1'b0;
        m_hist[i]  <= sig[i];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        tp[i]  = m_pend[i];
        tt[i]  = m_ptype[i];
        tov[i] = ovf_clr ? 1'b0 : m_ovf[i];
      end
      trr = m_rr;
      can = !m_valid || (evt_ready === 1'b1);
      win = -1;
      if (can) begin
        for (int k = 1; k <= N; k++) begin
          j = (trr + k) % N;
          if (win < 0 && tp[j]) win = j;
        end
        if (win >= 0) begin
          m_valid <= 1'b1;
          m_ch    <= win;
          m_fall  <= tt[win];
          tp[win] = 1'b0;
          trr     = win;
        end else begin
          m_valid <= 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        er = sig[i] && !m_hist[i] && cfg_rise[i];
        ef = !sig[i] && m_hist[i] && cfg_fall[i];
        if (er || ef) begin
          if (tp[i]) tov[i] = 1'b1;
          else begin
            tp[i] = 1'b1;
            tt[i] = ef;
          end
        end
      end
      m_rr <= trr;
      for (int i = 0; i < N; i++) begin
        m_pend[i]  <= tp[i];
        m_ptype[i] <= tt[i];
        m_ovf[i]   <= tov[i];
        m_hist[i]  <= sig[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] s, input logic [N-1:0] cr,
                          input logic [N-1:0] cf, input logic rdy, input int cycles);
    rst = 1'b1; sig = s; cfg_rise = cr; cfg_fall = cf; evt_ready = rdy; ovf_clr = 1'b0;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(4'b0001, 4'b0000, 4'b0001, 1'b1, 2);
    checks++;
    if (evt_valid !== 1'b0 || evt_ch !== 2'd0 || evt_fall !== 1'b0 || overflow !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got v=%b ch=%0d f=%b ovf=%b want v=0 ch=0 f=0 ovf=0000",
               evt_valid, evt_ch, evt_fall, overflow);
    end
  endtask

  task automatic test_single_fall();
    sig = 4'b0000;
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL fall_latency: got v=%b want v=0", evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_fall !== 1'b1) begin
      errors++;
      $display("FAIL fall_event: got v=%b ch=%0d f=%b want v=1 ch=0 f=1", evt_valid, evt_ch, evt_fall);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 4'b0000) begin
      errors++;
      $display("FAIL fall_one_cycle: got v=%b ovf=%b want v=0 ovf=0000", evt_valid, overflow);
    end
  endtask

  task automatic expect_order(input string nm, input int a, input int b);
    int exp_seq[2];
    exp_seq[0] = a; exp_seq[1] = b;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b1 || int'(evt_ch) != exp_seq[e]) begin
        errors++;
        $display("FAIL %s[%0d]: got v=%b ch=%0d want v=1 ch=%0d", nm, e, evt_valid, evt_ch, exp_seq[e]);
      end
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL %s_end: got v=%b want v=0", nm, evt_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset(4'b0000, 4'b1111, 4'b0000, 1'b1, 2);
    sig = 4'b1111;
    tick();
    for (int e = 0; e < N; e++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b1 || int'(evt_ch) != e || evt_fall !== 1'b0) begin
        errors++;
        $display("FAIL rr_all[%0d]: got v=%b ch=%0d f=%b want v=1 ch=%0d f=0", e, evt_valid, evt_ch, evt_fall, e);
      end
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL rr_all_end: got v=%b want v=0", evt_valid);
    end
    sig = 4'b0000; tick();
    sig = 4'b0101; tick();
    expect_order("rr_ptr3", 0, 2);
    sig = 4'b0111; tick();
    tick(); tick();
    sig = 4'b0000; tick();
    sig = 4'b0101; tick();
    expect_order("rr_ptr1", 2, 0);
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    do_reset(4'b0000, 4'b0010, 4'b0000, 1'b0, 2);
    sig = 4'b0010; tick();
    for (int c = 0; c < 6; c++) begin
      case (c)
        1, 3:    sig = 4'b0000;
        2, 4:    sig = 4'b0010;
        default: ;
      endcase
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b ch=%0d want v=1 ch=1", c, evt_valid, evt_ch);
      end
    end
    checks++;
    if (overflow !== 4'b0010) begin
      errors++; $display("FAIL bp_overflow: got %b want 0010", overflow);
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (evt_valid === 1'b1 && evt_ch === 2'd1) cnt++;
      tick();
    end
    checks++;
    if (cnt != 2) begin
      errors++; $display("FAIL bp_delivered: got %0d events want 2", cnt);
    end
  endtask

  task automatic test_grant_reload();
    do_reset(4'b0110, 4'b0000, 4'b0110, 1'b0, 2);
    sig = 4'b0100; tick();
    tick();
    sig = 4'b0000; tick();
    sig = 4'b0100; tick();
    sig = 4'b0000; evt_ready = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_fall !== 1'b1) begin
        errors++;
        $display("FAIL reload_evt[%0d]: got v=%b ch=%0d f=%b want v=1 ch=2 f=1", e, evt_valid, evt_ch, evt_fall);
      end
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 4'b0000) begin
      errors++;
      $display("FAIL reload_end: got v=%b ovf=%b want v=0 ovf=0000", evt_valid, overflow);
    end
  endtask

  task automatic test_reset_high();
    do_reset(4'b1111, 4'b1111, 4'b0000, 1'b1, 3);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        errors++; $display("FAIL rst_high_quiet[%0d]: got v=%b want v=0", c, evt_valid);
      end
    end
    evt_ready = 1'b0;
    sig = 4'b1100; tick();
    sig = 4'b1111; tick();
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
      errors++; $display("FAIL rst_mid_pre: got v=%b ch=%0d want v=1 ch=0", evt_valid, evt_ch);
    end
    rst = 1'b1; tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid: got v=%b want v=0", evt_valid);
    end
    rst = 1'b0; evt_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        errors++; $display("FAIL rst_mid_pend[%0d]: got v=%b want v=0", c, evt_valid);
      end
    end
  endtask

  task automatic test_ovf_clear();
    do_reset(4'b0000, 4'b1001, 4'b0000, 1'b0, 2);
    sig = 4'b0001; tick();
    tick();
    sig = 4'b0000; tick();
    sig = 4'b0001; tick();
    sig = 4'b0000; tick();
    sig = 4'b0001; tick();
    checks++;
    if (overflow !== 4'b0001) begin
      errors++; $display("FAIL ovf_pre: got %b want 0001", overflow);
    end
    sig = 4'b1001; tick();
    sig = 4'b0001; tick();
    sig = 4'b1001; ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 4'b1000) begin
      errors++; $display("FAIL ovf_clr_vs_set: got %b want 1000", overflow);
    end
  endtask

  task automatic test_random();
    bit exp_ovf_ok;
    do_reset(4'(($urandom)), 4'b1111, 4'b1111, 1'b1, 2);
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      sig       = 4'($urandom);
      if ($urandom_range(0, 15) == 0) cfg_rise = 4'($urandom);
      if ($urandom_range(0, 15) == 0) cfg_fall = 4'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      tick();
      exp_ovf_ok = 1'b1;
      for (int i = 0; i < N; i++) if (overflow[i] !== m_ovf[i]) exp_ovf_ok = 1'b0;
      checks++;
      if (evt_valid !== m_valid || !exp_ovf_ok ||
          (m_valid && (int'(evt_ch) != m_ch || evt_fall !== m_fall))) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b ch=%0d f=%b ovf=%b want v=%b ch=%0d f=%b ovf=%b%b%b%b",
                 c, evt_valid, evt_ch, evt_fall, overflow, m_valid, m_ch, m_fall,
                 m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sig = '0; cfg_rise = '0; cfg_fall = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_fall();
    test_round_robin();
    test_backpressure();
    test_grant_reload();
    test_reset_high();
    test_ovf_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
